// File: rtl/vm_pkg.sv
// Shared types and constants for the half-yuan vending machine.
package vm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StVend,
    StChange,
    StRefund
  } vm_state_e;

  localparam int unsigned HALF_VAL = 1;
  localparam int unsigned ONE_VAL  = 2;

  // Worst case credit is PRICE-1 plus both coins (3), so the register must hold PRICE+2.
  function automatic bit credit_w_ok(input int unsigned price, input int unsigned credit_w);
    longint unsigned cap;
    cap = (64'd1 << credit_w) - 64'd1;
    return (price >= 1) && (cap >= (64'(price) + 64'd2));
  endfunction

endpackage

// File: rtl/vm_coin_return.sv
// Down-count step and OChange pulse for coins paid back in the CHANGE and REFUND states.
module vm_coin_return
  import vm_pkg::*;
#(
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                active_i,
  input  logic [CREDIT_W-1:0] credit_i,
  output logic                pulse_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                last_o
);

  always_comb begin
    pulse_o  = active_i;
    credit_o = credit_i;
    last_o   = 1'b0;
    if (active_i) begin
      credit_o = credit_i - CREDIT_W'(1);
      last_o   = (credit_i <= CREDIT_W'(1));
    end
  end

endmodule

// File: rtl/vending_machine_chg.sv
// Coin-operated vending machine with refund; define VM_CHANGE_EN to pay back overpayment.
module vending_machine_chg
  import vm_pkg::*;
#(
  parameter int unsigned PRICE    = 5,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                sys_clk,
  input  logic                sysRstN,
  input  logic                piHalf,
  input  logic                piOne,
  input  logic                piCancel,
  output logic                OCola,
  output logic                OChange,
  output logic [CREDIT_W-1:0] OCredit,
  output logic                OBusy
);

  if (!credit_w_ok(PRICE, CREDIT_W)) begin : g_width_check
    $fatal(1, "vending_machine_chg: CREDIT_W too narrow for PRICE+2");
  end

  localparam int unsigned         SumW     = CREDIT_W + 1;
  localparam logic [SumW-1:0]     PriceExt = SumW'(PRICE);

  vm_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SumW-1:0]     coin_add, credit_sum;
  logic                ret_active, ret_pulse, ret_last;
  logic [CREDIT_W-1:0] ret_credit;

  always_comb begin
    coin_add   = (piHalf ? SumW'(HALF_VAL) : '0) + (piOne ? SumW'(ONE_VAL) : '0);
    credit_sum = {1'b0, credit_q} + coin_add;
    ret_active = (state_q == StChange) || (state_q == StRefund);
  end

  vm_coin_return #(
    .CREDIT_W(CREDIT_W)
  ) u_coin_return (
    .active_i(ret_active),
    .credit_i(credit_q),
    .pulse_o (ret_pulse),
    .credit_o(ret_credit),
    .last_o  (ret_last)
  );

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) begin
      state_q  <= StIdle;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    unique case (state_q)
      StIdle: begin
        if (credit_sum >= PriceExt) begin
          state_d  = StVend;
          credit_d = CREDIT_W'(credit_sum - PriceExt);
        end else if (coin_add != '0) begin
          state_d  = StCollect;
          credit_d = credit_sum[CREDIT_W-1:0];
        end
      end
      StCollect: begin
        // Cancel wins over completing the price; same-cycle coins join the refund.
        if (piCancel) begin
          state_d  = StRefund;
          credit_d = credit_sum[CREDIT_W-1:0];
        end else if (credit_sum >= PriceExt) begin
          state_d  = StVend;
          credit_d = CREDIT_W'(credit_sum - PriceExt);
        end else begin
          credit_d = credit_sum[CREDIT_W-1:0];
        end
      end
      StVend: begin
`ifdef VM_CHANGE_EN
        if (credit_q != '0) begin
          state_d = StChange;
        end else begin
          state_d  = StIdle;
          credit_d = '0;
        end
`else
        state_d  = StIdle;
        credit_d = '0;
`endif
      end
      StChange, StRefund: begin
        credit_d = ret_credit;
        if (ret_last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        credit_d = '0;
      end
    endcase
  end

  always_comb begin
    OCola   = (state_q == StVend);
    OChange = ret_pulse;
    OBusy   = (state_q == StVend) || (state_q == StChange) || (state_q == StRefund);
    OCredit = credit_q;
  end

endmodule

// File: tb/tb_vending_machine_chg.sv
// Directed and random checks of vending_machine_chg against a scripted-output reference model.
module tb_vending_machine_chg;

  localparam int unsigned PRICE = 5;
  localparam int unsigned CW    = 4;
`ifdef VM_CHANGE_EN
  localparam bit ChangeEn = 1'b1;
`else
  localparam bit ChangeEn = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sysRstN = 1'b0;
  logic          pi_half, pi_one, pi_cancel;
  logic          o_cola, o_chg, o_busy;
  logic [CW-1:0] o_credit;
  logic          p1_half, p1_one;
  logic          p1_cancel = 1'b0;
  logic          o1_cola, o1_chg, o1_busy;
  logic [1:0]    o1_credit;

  always #5 sys_clk = ~sys_clk;

  vending_machine_chg #(
    .PRICE   (PRICE),
    .CREDIT_W(CW)
  ) dut (
    .sys_clk (sys_clk),
    .sysRstN (sysRstN),
    .piHalf  (pi_half),
    .piOne   (pi_one),
    .piCancel(pi_cancel),
    .OCola   (o_cola),
    .OChange (o_chg),
    .OCredit (o_credit),
    .OBusy   (o_busy)
  );

  vending_machine_chg #(
    .PRICE   (1),
    .CREDIT_W(2)
  ) dut1 (
    .sys_clk (sys_clk),
    .sysRstN (sysRstN),
    .piHalf  (p1_half),
    .piOne   (p1_one),
    .piCancel(p1_cancel),
    .OCola   (o1_cola),
    .OChange (o1_chg),
    .OCredit (o1_credit),
    .OBusy   (o1_busy)
  );

  // Model: while a busy episode runs, its per-cycle outputs are pre-scripted in a queue.
  typedef struct packed {
    logic          cola;
    logic          chg;
    logic          busy;
    logic [CW-1:0] cr;
  } obs_t;

  obs_t script[$];
  int   m_credit;
  int   total, bad;
  int   cola_cnt, chg_cnt;

  function automatic obs_t m_expect();
    obs_t e;
    if (script.size() != 0) return script[0];
    e = '{cola: 1'b0, chg: 1'b0, busy: 1'b0, cr: CW'(m_credit)};
    return e;
  endfunction

  task automatic m_reset();
    script.delete();
    m_credit = 0;
  endtask

  task automatic m_edge(input bit h, input bit o, input bit c);
    int nc, rem;
    if (script.size() != 0) begin
      void'(script.pop_front());
      if (script.size() == 0) m_credit = 0;
      return;
    end
    nc = m_credit + (h ? 1 : 0) + (o ? 2 : 0);
    if (c && m_credit > 0) begin
      for (int i = nc; i > 0; i--) script.push_back('{cola: 1'b0, chg: 1'b1, busy: 1'b1, cr: CW'(i)});
    end else if (nc >= int'(PRICE)) begin
      rem = nc - int'(PRICE);
      script.push_back('{cola: 1'b1, chg: 1'b0, busy: 1'b1, cr: CW'(rem)});
      if (ChangeEn) begin
        for (int i = rem; i > 0; i--) script.push_back('{cola: 1'b0, chg: 1'b1, busy: 1'b1, cr: CW'(i)});
      end
      m_credit = 0;
    end else begin
      m_credit = nc;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    obs_t e;
    e = m_expect();
    chk({tag, ".cola"}, 32'(o_cola), 32'(e.cola));
    chk({tag, ".chg"}, 32'(o_chg), 32'(e.chg));
    chk({tag, ".busy"}, 32'(o_busy), 32'(e.busy));
    chk({tag, ".credit"}, 32'(o_credit), 32'(e.cr));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit h, input bit o, input bit c, input string tag);
    pi_half   = h;
    pi_one    = o;
    pi_cancel = c;
    @(posedge sys_clk);
    m_edge(h, o, c);
    #1;
    cola_cnt += int'(o_cola);
    chg_cnt  += int'(o_chg);
    check_model(tag);
    @(negedge sys_clk);
    pi_half   = 1'b0;
    pi_one    = 1'b0;
    pi_cancel = 1'b0;
  endtask

  // Asserts reset mid-cycle, checks outputs drop without a clock edge, releases at next negedge.
  task automatic async_reset(input string tag);
    #2;
    sysRstN = 1'b0;
    #1;
    chk({tag, ".cola"}, 32'(o_cola), 0);
    chk({tag, ".chg"}, 32'(o_chg), 0);
    chk({tag, ".busy"}, 32'(o_busy), 0);
    chk({tag, ".credit"}, 32'(o_credit), 0);
    chk({tag, ".p1_credit"}, 32'(o1_credit), 0);
    m_reset();
    @(negedge sys_clk);
    sysRstN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    pi_half = 1'b0;
    pi_one = 1'b0;
    pi_cancel = 1'b0;
    p1_half = 1'b0;
    p1_one = 1'b0;
    m_reset();
    @(negedge sys_clk);
    async_reset("reset");

    // Five half coins; the first is sampled on the first edge after release.
    cola_cnt = 0;
    chg_cnt = 0;
    repeat (5) step(1'b1, 1'b0, 1'b0, "half5");
    chk("half5.cola_now", 32'(o_cola), 1);
    repeat (2) step(1'b0, 1'b0, 1'b0, "half5");
    chk("half5.cola_cnt", 32'(cola_cnt), 1);
    chk("half5.chg_cnt", 32'(chg_cnt), 0);
    chk("half5.credit", 32'(o_credit), 0);

    // Three one-yuan coins overpay by one half.
    cola_cnt = 0;
    chg_cnt = 0;
    repeat (3) step(1'b0, 1'b1, 1'b0, "one3");
    chk("one3.vend_credit", 32'(o_credit), 1);
    repeat (3) step(1'b0, 1'b0, 1'b0, "one3");
    chk("one3.cola_cnt", 32'(cola_cnt), 1);
    chk("one3.chg_cnt", 32'(chg_cnt), ChangeEn ? 1 : 0);
    chk("one3.credit", 32'(o_credit), 0);

    // Both coins at once, then exact price.
    cola_cnt = 0;
    chg_cnt = 0;
    step(1'b1, 1'b1, 1'b0, "mix");
    chk("mix.credit3", 32'(o_credit), 3);
    step(1'b0, 1'b1, 1'b0, "mix");
    chk("mix.cola", 32'(o_cola), 1);
    repeat (2) step(1'b0, 1'b0, 1'b0, "mix");
    chk("mix.chg_cnt", 32'(chg_cnt), 0);

    // Cancel after 1.5 yuan; coins during the refund are ignored.
    cola_cnt = 0;
    chg_cnt = 0;
    step(1'b0, 1'b1, 1'b0, "refund");
    step(1'b1, 1'b0, 1'b0, "refund");
    step(1'b0, 1'b0, 1'b1, "refund");
    chk("refund.credit3", 32'(o_credit), 3);
    step(1'b1, 1'b1, 1'b0, "refund");
    chk("refund.credit2", 32'(o_credit), 2);
    step(1'b0, 1'b1, 1'b1, "refund");
    chk("refund.credit1", 32'(o_credit), 1);
    step(1'b1, 1'b0, 1'b0, "refund");
    chk("refund.credit0", 32'(o_credit), 0);
    chk("refund.chg_cnt", 32'(chg_cnt), 3);
    chk("refund.cola_cnt", 32'(cola_cnt), 0);
    step(1'b0, 1'b0, 1'b0, "refund");

    // Cancel in IDLE with no credit does nothing.
    step(1'b0, 1'b0, 1'b1, "idle_cancel");
    chk("idle_cancel.busy", 32'(o_busy), 0);

    // Reset in the middle of a refund forfeits the rest.
    step(1'b0, 1'b1, 1'b0, "rst_refund");
    step(1'b0, 1'b1, 1'b0, "rst_refund");
    step(1'b0, 1'b0, 1'b1, "rst_refund");
    step(1'b0, 1'b0, 1'b0, "rst_refund");
    async_reset("rst_refund.async");
    step(1'b0, 1'b0, 1'b0, "rst_refund.after");

`ifdef VM_CHANGE_EN
    step(1'b0, 1'b1, 1'b0, "rst_change");
    step(1'b0, 1'b1, 1'b0, "rst_change");
    step(1'b1, 1'b1, 1'b0, "rst_change");
    step(1'b0, 1'b0, 1'b0, "rst_change");
    chk("rst_change.in_change", 32'(o_chg), 1);
    async_reset("rst_change.async");
    step(1'b0, 1'b0, 1'b0, "rst_change.after");
`endif

    // PRICE=1 instance: 1.5 yuan pays 0.5 and leaves two halves over.
    p1_half = 1'b1;
    p1_one  = 1'b1;
    step(1'b0, 1'b0, 1'b0, "p1");
    p1_half = 1'b0;
    p1_one  = 1'b0;
    chk("p1.cola", 32'(o1_cola), 1);
    chk("p1.vend_credit", 32'(o1_credit), 2);
    chk("p1.vend_busy", 32'(o1_busy), 1);
    step(1'b0, 1'b0, 1'b0, "p1");
    chk("p1.chg_a", 32'(o1_chg), ChangeEn ? 1 : 0);
    chk("p1.credit_a", 32'(o1_credit), ChangeEn ? 2 : 0);
    step(1'b0, 1'b0, 1'b0, "p1");
    chk("p1.chg_b", 32'(o1_chg), ChangeEn ? 1 : 0);
    chk("p1.credit_b", 32'(o1_credit), ChangeEn ? 1 : 0);
    step(1'b0, 1'b0, 1'b0, "p1");
    chk("p1.chg_end", 32'(o1_chg), 0);
    chk("p1.busy_end", 32'(o1_busy), 0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) async_reset("rand.rst");
      step($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_machine_chg.md
VENDING_MACHINE_CHG -- requirements
Module: vending_machine_chg

Interface
REQ-001 SHALL have parameter PRICE, default 5, meaning product price in half-yuan units (5 = 2.5 yuan), legal range 1..(2^CREDIT_W-3).
REQ-002 SHALL have parameter CREDIT_W, default 4, meaning credit register width; elaboration SHALL fail if 2^CREDIT_W-1 < PRICE+2.
REQ-003 SHALL have port sys_clk, input, 1 bit, clock; all state updates on rising edge.
REQ-004 SHALL have port sysRstN, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port piHalf, input, 1 bit, one 0.5-yuan coin per sampled high cycle.
REQ-006 SHALL have port piOne, input, 1 bit, one 1-yuan coin per sampled high cycle.
REQ-007 SHALL have port piCancel, input, 1 bit, request refund of current credit.
REQ-008 SHALL have port OCola, output, 1 bit, product dispense pulse.
REQ-009 SHALL have port OChange, output, 1 bit, one 0.5-yuan coin returned per high cycle.
REQ-010 SHALL have port OCredit, output, CREDIT_W bits, current credit in half-yuan units.
REQ-011 SHALL have port OBusy, output, 1 bit, high when coins are not accepted.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, COLLECT, VEND, CHANGE, REFUND; all outputs decoded from registered state and credit only.
REQ-013 In IDLE/COLLECT, each cycle SHALL add piHalf*1 + piOne*2 to credit; both high in one cycle adds 3.
REQ-014 IDLE SHALL go to COLLECT when the added value is nonzero and the new credit < PRICE.
REQ-015 When new credit >= PRICE, next state SHALL be VEND with credit = new credit - PRICE, so OCola is high exactly one cycle, in the cycle after the edge that sampled the completing coin.
REQ-016 VEND SHALL go to CHANGE if remaining credit > 0 (CHANGE_EN defined), else IDLE with credit 0.
REQ-017 CHANGE and REFUND SHALL assert OChange for exactly one cycle per remaining half-unit, decrementing credit by 1 per cycle, then return to IDLE when credit reaches 0.
REQ-018 piCancel sampled in COLLECT SHALL go to REFUND; coins sampled in the same cycle SHALL be added and included in the refund; piCancel has priority over reaching PRICE.
REQ-019 piCancel in IDLE with zero credit SHALL be ignored.
REQ-020 OBusy SHALL be high in VEND, CHANGE, REFUND; coins and piCancel in those states SHALL be ignored (not credited).
REQ-021 OCredit SHALL never exceed PRICE+2; no wrap-around is permitted.

Reset
REQ-022 sysRstN low SHALL immediately force state IDLE, credit 0, OCola 0, OChange 0, OBusy 0, OCredit 0, including mid-VEND/CHANGE/REFUND; pending change is forfeited.
REQ-023 First coin after reset release SHALL be sampled on the first rising edge with sysRstN high.

Configuration
REQ-024 Macro VM_CHANGE_EN defined: overpayment after VEND SHALL be returned via CHANGE state.
REQ-025 VM_CHANGE_EN undefined: VEND SHALL always go to IDLE with credit cleared (excess forfeited); CHANGE state unused; REFUND SHALL remain functional.

Structure
REQ-026 Package vm_pkg SHALL hold the state enum typedef, coin value constants (HALF_VAL=1, ONE_VAL=2) and the width-check function.
REQ-027 Change/refund down-counter with OChange pulse generation SHALL be sub-module vm_coin_return, shared by CHANGE and REFUND.

Verification (PRICE=5, CREDIT_W=4 unless noted)
REQ-028 Five piHalf single-cycle pulses -> OCola high one cycle, no OChange, OCredit 0, IDLE.
REQ-029 piOne x3 with VM_CHANGE_EN -> OCola one cycle, then OChange one cycle, OCredit 1->0; without macro -> OCola only, OCredit 0.
REQ-030 piHalf+piOne same cycle, then piOne -> credit 3 then 5, OCola one cycle, no change.
REQ-031 piOne, piHalf, then piCancel -> REFUND, OChange 3 consecutive cycles, OCredit 3->2->1->0, no OCola.
REQ-032 Coin pulses during OBusy -> ignored, OCredit unchanged; sysRstN low mid-CHANGE -> all outputs 0 asynchronously, IDLE after release.
REQ-033 PRICE=1, CREDIT_W=2, piHalf+piOne same cycle -> OCola, then 2 OChange pulses (VM_CHANGE_EN).
